// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive path.
//   rx_state_e  : receiver FSM states (also exported on the debug port)
//   PAR_*       : parity-mode encodings of the 'parity' input
//   rx_entry_t  : one receive FIFO entry {data, parity_err, frame_err, break_det}
//   maj3        : 2-of-3 majority used for the bit vote
package uart_rx_pkg;

  localparam int unsigned PKG_DATA_W = 9;  // widest frame any instance may carry

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  // parity[1]=0 means no parity bit, whatever parity[0] holds
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_ODD  = 2'b11;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] data;
    logic                  parity_err;
    logic                  frame_err;
    logic                  break_det;
  } rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding completed receive frames.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   push_i/push_data_i : write request and entry
//   pop_i         : consumer pop (ignored when empty)
//   head_o        : entry at the head (meaningful only when !empty_o)
//   empty_o       : FIFO holds no entries
//   drop_o        : push refused because the FIFO is full and not popping
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit distinguishes full from empty; pointers wrap
  // naturally because DEPTH is a power of two.
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, pop_ok, push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: oversampled start detection, 3-sample majority vote per
// bit, optional parity, one or two stop bits, break detection, and a small
// receive FIFO with overrun reporting.
//   PCLK, PRESETn   : clock, asynchronous active-low reset
//   rx_tick         : oversample enable (OVERSAMPLE pulses per bit)
//   RX              : asynchronous serial line, idle high
//   rx_en           : receiver enable; dropping it aborts a frame
//   frame_length, parity, stop_bit : frame format, latched at start
//   rx_data, rx_valid, rx_ready    : FIFO head and pop handshake
//   parity_err, frame_err, break_det : status of the FIFO head
//   overrun         : one-cycle pulse when a completed frame is dropped
//   state_dbg       : current receiver FSM state
//
// Handshake: an entry is consumed on a rising PCLK edge where rx_valid and
// rx_ready are both high; rx_valid never depends on rx_ready.
module uart_rx_framer
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_MAX   = 9,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                rx_tick,
  input  logic                RX,
  input  logic                rx_en,
  input  logic [3:0]          frame_length,
  input  logic [1:0]          parity,
  input  logic                stop_bit,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                overrun,
  output rx_state_e           state_dbg
);

  localparam int unsigned TCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] TICK_S0   = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TICK_S1   = TCW'(OVERSAMPLE / 2);
  localparam logic [TCW-1:0] TICK_VOTE = TCW'(OVERSAMPLE / 2 + 1);

  rx_state_e           state_q, state_d;
  logic [TCW-1:0]      tick_cnt_q, tick_cnt_d, tick_idx;
  logic [3:0]          bit_cnt_q, bit_cnt_d, len_q, len_d;
  logic [DATA_MAX-1:0] data_q, data_d;
  logic [1:0]          par_q, par_d, smp_q, smp_d, sync_ok_q;
  logic                two_stop_q, two_stop_d, par_bit_q, par_bit_d;
  logic                perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic                armed_q, armed_d, rx_s1_q, rx_s2_q, overrun_q;
  logic                rx_sync, vote, push, drop, fifo_empty;
  rx_entry_t           push_entry, head_entry;

  assign rx_sync = rx_s2_q;
  // Index of the tick being processed now within the current bit.
  assign tick_idx = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
  assign vote = maj3(smp_q[0], smp_q[1], rx_sync);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    len_d      = len_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    smp_d      = smp_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    push       = 1'b0;
    // A start is only accepted after the line has been seen high, so a line
    // that is low out of reset or still low after a break is not a new frame.
    armed_d    = armed_q | (sync_ok_q[1] & rx_sync);

    if (state_q != ST_IDLE && !rx_en) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (rx_tick && rx_en && armed_q && !rx_sync) begin
        state_d    = ST_START;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        data_d     = '0;
        par_bit_d  = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        brk_d      = 1'b0;
        armed_d    = 1'b0;
        par_d      = parity;
        two_stop_d = stop_bit;
        if (frame_length < 4'd5)                len_d = 4'd5;
        else if (frame_length > 4'(DATA_MAX))   len_d = 4'(DATA_MAX);
        else                                    len_d = frame_length;
      end
    end else if (rx_tick) begin
      tick_cnt_d = tick_idx;
      if (tick_idx == TICK_S0) smp_d[0] = rx_sync;
      if (tick_idx == TICK_S1) smp_d[1] = rx_sync;
      case (state_q)
        ST_START: begin
          if (tick_idx == TICK_VOTE && vote) state_d = ST_IDLE;  // false start
          else if (tick_idx == TICK_LAST)    state_d = ST_DATA;
        end
        ST_DATA: begin
          if (tick_idx == TICK_VOTE) data_d = data_q | (DATA_MAX'(vote) << bit_cnt_q);
          if (tick_idx == TICK_LAST) begin
            if (bit_cnt_q == 4'(len_q - 4'd1)) state_d = par_q[1] ? ST_PARITY : ST_STOP1;
            else                               bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_PARITY: begin
          if (tick_idx == TICK_VOTE) begin
            par_bit_d = vote;
            // par_q[0] inverts the XOR for odd parity
            perr_d    = vote != ((^data_q) ^ par_q[0]);
          end
          if (tick_idx == TICK_LAST) state_d = ST_STOP1;
        end
        ST_STOP1: begin
          if (tick_idx == TICK_VOTE) begin
            ferr_d = !vote;
            brk_d  = (data_q == '0) && !par_bit_q && !vote;
            if (!two_stop_q) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (tick_idx == TICK_LAST && two_stop_q) begin
            state_d = ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (tick_idx == TICK_VOTE) begin
            ferr_d  = ferr_q | !vote;
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.data       = PKG_DATA_W'(data_q);
    push_entry.parity_err = perr_q;
    push_entry.frame_err  = ferr_d;
    push_entry.break_det  = brk_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      len_q      <= '0;
      par_q      <= PAR_NONE;
      two_stop_q <= 1'b0;
      smp_q      <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      armed_q    <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      sync_ok_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      len_q      <= len_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
      smp_q      <= smp_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      armed_q    <= armed_d;
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      // Marks the synchroniser as holding real line samples, not reset values.
      sync_ok_q  <= {sync_ok_q[0], 1'b1};
      overrun_q  <= drop;
    end
  end

  uart_rx_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (rx_ready),
    .head_o     (head_entry),
    .empty_o    (fifo_empty),
    .drop_o     (drop)
  );

  // Head fields are forced to zero while empty so outputs are clean after reset.
  assign rx_valid   = !fifo_empty;
  assign rx_data    = fifo_empty ? '0 : head_entry.data[DATA_MAX-1:0];
  assign parity_err = !fifo_empty && head_entry.parity_err;
  assign frame_err  = !fifo_empty && head_entry.frame_err;
  assign break_det  = !fifo_empty && head_entry.break_det;
  assign overrun    = overrun_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
module tb_uart_rx_framer;
  import uart_rx_pkg::*;

  localparam int DATA_MAX = 9;
  localparam int OS       = 16;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 8;
  localparam int BIT_CLK  = OS * TICK_DIV;  // nominal bit time in PCLK cycles
  localparam int W        = 12;

  logic                PCLK = 1'b0;
  logic                PRESETn = 1'b0;
  logic                rx_tick = 1'b0;
  logic                RX = 1'b1;
  logic                rx_en = 1'b1;
  logic [3:0]          frame_length = 4'd8;
  logic [1:0]          parity = 2'b00;
  logic                stop_bit = 1'b0;
  logic [DATA_MAX-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready = 1'b1;
  logic                parity_err, frame_err, break_det, overrun;
  rx_state_e           state_dbg;

  logic [W-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ovr_seen = 0;
  int  ovr_exp = 0;
  bit  ready_rand = 1'b0;
  logic ready_fixed = 1'b1;

  uart_rx_framer #(.DATA_MAX(DATA_MAX), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .rx_tick(rx_tick), .RX(RX), .rx_en(rx_en),
    .frame_length(frame_length), .parity(parity), .stop_bit(stop_bit),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
    .overrun(overrun), .state_dbg(state_dbg)
  );

  // ---------------- clock / tick / ready generation ----------------
  always #5 PCLK = ~PCLK;

  initial forever begin
    repeat (TICK_DIV - 1) @(posedge PCLK);
    #1 rx_tick = 1'b1;
    @(posedge PCLK);
    #1 rx_tick = 1'b0;
  end

  initial forever begin
    @(posedge PCLK);
    #1 rx_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  initial begin
    #(1_500_000 * 1ns);
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over an entry.
  initial forever begin
    @(negedge PCLK);
    if (overrun === 1'b1) ovr_seen++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got %h required no entry",
                 {rx_data, parity_err, frame_err, break_det});
      end else begin
        check("rx_entry", 32'({rx_data, parity_err, frame_err, break_det}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected FIFO entry from the frame contents as they appear on the line.
  function automatic logic [W-1:0] model_entry(input int len, input logic [8:0] d,
                                               input logic [1:0] par, input logic pbit,
                                               input logic par_ok, input logic two_stop,
                                               input logic s1, input logic s2);
    logic perr, ferr, brk;
    perr = par[1] && !par_ok;
    ferr = !s1 || (two_stop && !s2);
    brk  = (d == 9'd0) && (!par[1] || !pbit) && !s1;
    return {d, perr, ferr, brk};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Drives one frame. rst_at_bit >= 0 pulses PRESETn in the middle of that
  // line bit, in which case the frame is expected to vanish.
  task automatic send_frame(input int len, input logic [8:0] data, input logic [1:0] par,
                            input logic two_stop, input logic par_ok, input logic s1,
                            input logic s2, input int bit_clk, input bit expect_push,
                            input int rst_at_bit);
    logic [8:0] d;
    logic pbit;
    logic bits[$];
    bit did_rst;
    did_rst = 1'b0;
    d = data & 9'((1 << len) - 1);
    pbit = 1'(($countones(d) % 2) == 1) ^ par[0] ^ !par_ok;
    bits.push_back(1'b0);
    for (int i = 0; i < len; i++) bits.push_back(d[i]);
    if (par[1]) bits.push_back(pbit);
    bits.push_back(s1);
    if (two_stop) bits.push_back(s2);
    frame_length = 4'(len);
    parity = par;
    stop_bit = two_stop;
    for (int k = 0; k < bits.size(); k++) begin
      RX = bits[k];
      // Format inputs must be ignored once the frame has started.
      if (k == 1) begin
        frame_length = 4'($urandom_range(5, 9));
        parity = 2'($urandom_range(0, 3));
        stop_bit = 1'($urandom_range(0, 1));
      end
      if (k == bits.size() - 1 && expect_push && !did_rst)
        exp_q.push_back(model_entry(len, d, par, pbit, par_ok, two_stop, s1, s2));
      if (k == rst_at_bit) begin
        cycles(bit_clk / 2);
        PRESETn = 1'b0;
        cycles(3);
        PRESETn = 1'b1;
        did_rst = 1'b1;
        cycles(bit_clk - bit_clk / 2 - 3);
      end else begin
        cycles(bit_clk);
      end
    end
    RX = 1'b1;
    cycles(bit_clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_valid === 1'b1) && n < 6000) begin
      cycles(1);
      n++;
    end
    if (n >= 6000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d entries pending after timeout, required 0", name, exp_q.size());
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    cycles(5);
    @(negedge PCLK);
    check("reset_outputs",
          32'({rx_valid, rx_data, parity_err, frame_err, break_det, overrun, state_dbg}),
          32'({1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE}));
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    cycles(BIT_CLK);

    // 8N1 0xA5
    send_frame(8, 9'h0A5, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b1, BIT_CLK, 1'b1, -1);
    wait_drain("8n1");

    // 7E2 0x35 with the parity bit driven wrong (1)
    send_frame(7, 9'h035, PAR_EVEN, 1'b1, 1'b0, 1'b1, 1'b1, BIT_CLK, 1'b1, -1);
    wait_drain("7e2");

    // False start: low for 5 ticks
    RX = 1'b0;
    cycles(5 * TICK_DIV);
    RX = 1'b1;
    cycles(2 * BIT_CLK);
    @(negedge PCLK);
    check("false_start_state", 32'(state_dbg), 32'(ST_IDLE));
    check("false_start_valid", 32'(rx_valid), 32'd0);

    // Break: 8N1 line low for two frame times, one entry only
    frame_length = 4'd8;
    parity = PAR_NONE;
    stop_bit = 1'b0;
    #1 RX = 1'b0;
    exp_q.push_back({9'd0, 1'b0, 1'b1, 1'b1});
    cycles(20 * BIT_CLK);
    RX = 1'b1;
    cycles(BIT_CLK);
    wait_drain("break");

    // rx_en dropped in the middle of the data bits
    frame_length = 4'd8;
    RX = 1'b0;
    cycles(BIT_CLK);
    RX = 1'b1;
    cycles(3 * BIT_CLK + BIT_CLK / 2);
    @(negedge PCLK);
    check("abort_mid_state", 32'(state_dbg), 32'(ST_DATA));
    @(posedge PCLK);
    #1 rx_en = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    #1 RX = 1'b0;
    cycles(3 * BIT_CLK);
    RX = 1'b1;
    cycles(2 * BIT_CLK);
    rx_en = 1'b1;
    cycles(BIT_CLK);
    @(negedge PCLK);
    check("abort_no_entry", 32'(rx_valid), 32'd0);
    #1;

    // Overrun: 5 frames into a depth-4 FIFO with no consumer
    ready_fixed = 1'b0;
    cycles(2);
    for (int i = 1; i <= 5; i++) begin
      send_frame(8, 9'(i), PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b1, BIT_CLK, i <= DEPTH, -1);
      if (i > DEPTH) ovr_exp++;
    end
    @(negedge PCLK);
    check("overrun_pulses", 32'(ovr_seen), 32'(ovr_exp));
    check("full_valid", 32'(rx_valid), 32'd1);
    #1 ready_fixed = 1'b1;
    cycles(2);
    wait_drain("overrun");

    // 9O1 0x1FF with baud skew +/-3%
    send_frame(9, 9'h1FF, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b1, BIT_CLK * 103 / 100, 1'b1, -1);
    wait_drain("skew_slow");
    send_frame(9, 9'h1FF, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b1, BIT_CLK * 97 / 100, 1'b1, -1);
    wait_drain("skew_fast");

    // Reset pulsed during the parity bit (line bit 10) of a 9O1 frame
    send_frame(9, 9'h1FF, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b1, BIT_CLK, 1'b0, 10);
    @(negedge PCLK);
    check("reset_mid_valid", 32'(rx_valid), 32'd0);
    check("reset_mid_state", 32'(state_dbg), 32'(ST_IDLE));
    #1;
    send_frame(9, 9'h0AB, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b1, BIT_CLK, 1'b1, -1);
    wait_drain("after_reset");

    // Randomised frames with a randomly stalling consumer
    ready_rand = 1'b1;
    for (int n = 0; n < 16; n++) begin
      send_frame($urandom_range(5, 9), 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                 BIT_CLK, 1'b1, -1);
    end
    wait_drain("random");
    ready_rand = 1'b0;
    cycles(BIT_CLK);

    @(negedge PCLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("overrun_total", 32'(ovr_seen), 32'(ovr_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter DATA_MAX, default 9, maximum data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, rx_tick pulses per bit (even, 8..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-004 PCLK  input  1  system clock; all state changes on rising edge.
REQ-005 PRESETn  input  1  reset, asynchronous, active-low.
REQ-006 rx_tick  input  1  oversample enable, single-PCLK pulse, OVERSAMPLE pulses per bit time.
REQ-007 RX  input  1  serial line, asynchronous, idle high.
REQ-008 rx_en  input  1  receiver enable.
REQ-009 frame_length  input  4  data bits per frame, 5..DATA_MAX.
REQ-010 parity  input  2  0x none, 10 even, 11 odd.
REQ-011 stop_bit  input  1  0 = one stop bit, 1 = two stop bits.
REQ-012 rx_data  output  DATA_MAX  FIFO head data, LSB first on line, zero-extended above frame_length.
REQ-013 rx_valid  output  1  FIFO non-empty.
REQ-014 rx_ready  input  1  consumer pop; pop occurs when rx_valid && rx_ready.
REQ-015 parity_err, frame_err, break_det  output  1 each  status of FIFO head entry, valid with rx_valid.
REQ-016 overrun  output  1  one-PCLK pulse when a completed frame is dropped.

Function
REQ-017 RX SHALL pass through a two-flop synchroniser; all sampling SHALL use the synchronised value.
REQ-018 frame_length, parity and stop_bit SHALL be latched on start detection and held constant for the frame.
REQ-019 States: IDLE, START, DATA, PARITY, STOP1, STOP2; tick counter counts rx_tick modulo OVERSAMPLE per bit.
REQ-020 IDLE->START on synchronised RX low at an rx_tick while rx_en=1; the tick counter is cleared.
REQ-021 Each bit value SHALL be the majority of three samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-022 START: if the start-bit vote is 1, SHALL return to IDLE with no FIFO write (false start); otherwise go to DATA at bit end.
REQ-023 DATA: frame_length bits shifted LSB first; after the last bit go to PARITY if parity[1]=1, else STOP1.
REQ-024 parity_err=1 when the received parity bit differs from the computed one (even: XOR of data; odd: inverted XOR of data).
REQ-025 STOP1: frame_err=1 if the vote is 0; with stop_bit=0, the frame completes at the STOP1 vote tick and goes to IDLE (no wait to bit end).
REQ-026 STOP2: entered at STOP1 bit end when stop_bit=1; the frame completes at the STOP2 vote tick; a 0 vote in either stop bit sets frame_err.
REQ-027 break_det=1 when all data bits, the parity bit if present, and STOP1 vote 0; frame_err SHALL also be 1.
REQ-028 On completion, {data, parity_err, frame_err, break_det} SHALL be pushed in the same PCLK cycle; rx_valid rises the next cycle if the FIFO was empty.
REQ-029 Completion with the FIFO full SHALL drop the new frame, keep FIFO contents, and pulse overrun for 1 cycle.
REQ-030 A simultaneous push and pop on a full FIFO SHALL succeed without overrun.
REQ-031 rx_en deasserted mid-frame SHALL abort to IDLE next cycle with no push; the FIFO is retained.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a pop when empty SHALL be ignored.

Reset
REQ-033 On PRESETn low: state IDLE, counters 0, synchroniser flops 1, FIFO empty.
REQ-034 On PRESETn low: rx_valid, overrun, parity_err, frame_err, break_det 0, rx_data 0.
REQ-035 Reset asserted mid-frame SHALL discard the frame; after release, reception restarts only on a new falling edge.

Structure
REQ-036 Package uart_rx_pkg SHALL hold the state enum, the parity-mode constants (NONE, EVEN=2'b10, ODD=2'b11) and the FIFO entry struct.
REQ-037 The FIFO SHALL be sub-module uart_rx_fifo (parametrised width/depth, first-word fall-through).

Verification
REQ-038 8N1, byte 0xA5, OVERSAMPLE=16 -> one entry, rx_data=0x0A5, all error flags 0.
REQ-039 7E2, data 0x35, parity bit driven 1 (correct parity is 0) -> rx_data=0x035, parity_err=1, frame_err=0.
REQ-040 RX low for 5 ticks then high -> no FIFO write, state IDLE.
REQ-041 8N1, line held low for 2 frame times -> entry with rx_data=0, frame_err=1, break_det=1.
REQ-042 FIFO_DEPTH=4, rx_ready=0, 5 frames 0x01..0x05 -> overrun pulses once; pops return 0x01..0x04.
REQ-043 9O1 frame 0x1FF with ±3% baud skew, and PRESETn pulsed mid-frame -> skewed frame received correctly; after reset rx_valid=0 and the next full frame is received correctly.
